// File: rtl/secuenciador_dispensado_pkg.sv
// Shared definitions for the dispense sequencer: state/fase encoding, cup-size codes,
// default phase times and the latched recipe record.
package secuenciador_dispensado_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        MOLER  = 3'b001,
        AGUA   = 3'b010,
        LECHE  = 3'b011,
        ESPUMA = 3'b100,
        AZUCAR = 3'b101,
        DONE   = 3'b110
    } estado_t;

    localparam logic [1:0] TAM_PEQUENO  = 2'b00;
    localparam logic [1:0] TAM_MEDIANO  = 2'b01;
    localparam logic [1:0] TAM_GRANDE   = 2'b10;
    localparam logic [1:0] TAM_INVALIDO = 2'b11;

    localparam int AZUCAR_MAX   = 5;
    localparam int T_MOLER_DEF  = 4;
    localparam int T_AGUA_DEF   = 4;
    localparam int T_LECHE_DEF  = 6;
    localparam int T_ESPUMA_DEF = 4;
    localparam int T_AZUCAR_DEF = 2;

    typedef struct packed {
        logic       concentracion;
        logic       leche;
        logic       espuma;
        logic [2:0] azucar;
        logic [1:0] tamano;
    } receta_t;

endpackage

// File: rtl/secuenciador_dispensado_temporizador_fase.sv
// Loadable 8-bit down-counter timing one dispense phase; holds at zero until reloaded.
module temporizador_fase (
    input  logic       clk,
    input  logic       reset,
    input  logic       carga,
    input  logic [7:0] valor_carga,
    output logic [7:0] valor,
    output logic       cero
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valor <= '0;
        end else if (carga) begin
            valor <= valor_carga;
        end else if (valor != 8'd0) begin
            valor <= valor - 8'd1;
        end
    end

    assign cero = (valor == 8'd0);

endmodule

// File: rtl/secuenciador_dispensado.sv
// Coffee dispense sequencer: grind, water, milk, foam, sugar, then a one-cycle DONE.
// Optional macro SECUENCIA_CANCELAR_EN adds a cancelar input that aborts a running drink.
module secuenciador_dispensado
    import secuenciador_dispensado_pkg::*;
#(
    parameter int T_MOLER  = T_MOLER_DEF,
    parameter int T_AGUA   = T_AGUA_DEF,
    parameter int T_LECHE  = T_LECHE_DEF,
    parameter int T_ESPUMA = T_ESPUMA_DEF,
    parameter int T_AZUCAR = T_AZUCAR_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       concentracion,
    input  logic       leche,
    input  logic       espuma,
    input  logic [2:0] azucar_anadido,
    input  logic [1:0] tamano,
`ifdef SECUENCIA_CANCELAR_EN
    input  logic       cancelar,
`endif
    output logic       molino,
    output logic       valvula_agua,
    output logic       valvula_leche,
    output logic       espumador,
    output logic       dosif_azucar,
    output logic       ocupado,
    output logic       listo,
    output logic       error_sel,
    output logic [2:0] fase
);

    estado_t    estado, estado_sig;
    receta_t    receta, receta_ef;
    logic [7:0] len_moler, len_agua, len_leche, len_espuma, len_azucar;
    logic [7:0] duracion, cnt_valor;
    logic       cnt_cero, cnt_carga, arranque_ok;
    logic       molino_d, agua_d, leche_d, espuma_d, azucar_d, ocupado_d, listo_d, error_d;

    // First phase after 'desde' with a non-zero length; DONE when nothing remains.
    function automatic estado_t primera_fase(estado_t desde, logic [7:0] l_mol, l_agu,
                                             l_lec, l_esp, l_azu);
        estado_t r;
        r = DONE;
        if (desde < AZUCAR && l_azu != 8'd0) r = AZUCAR;
        if (desde < ESPUMA && l_esp != 8'd0) r = ESPUMA;
        if (desde < LECHE  && l_lec != 8'd0) r = LECHE;
        if (desde < AGUA   && l_agu != 8'd0) r = AGUA;
        if (desde < MOLER  && l_mol != 8'd0) r = MOLER;
        return r;
    endfunction

    // In IDLE the lengths come straight from the inputs so the first phase can start on the start edge.
    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        receta_ef = receta;
        if (estado == IDLE) begin
            receta_ef.concentracion = concentracion;
            receta_ef.leche         = leche;
            receta_ef.espuma        = espuma;
            receta_ef.azucar        = (azucar_anadido > 3'(AZUCAR_MAX)) ? 3'(AZUCAR_MAX) : azucar_anadido;
            receta_ef.tamano        = tamano;
        end
    end

    assign arranque_ok = (estado == IDLE) && start && (tamano != TAM_INVALIDO);
    assign len_moler   = 8'(T_MOLER) << receta_ef.concentracion;
    assign len_agua    = 8'(T_AGUA * (int'(receta_ef.tamano) + 1));
    assign len_leche   = receta_ef.leche  ? 8'(T_LECHE)  : 8'd0;
    assign len_espuma  = receta_ef.espuma ? 8'(T_ESPUMA) : 8'd0;
    assign len_azucar  = 8'(T_AZUCAR * int'(receta_ef.azucar));

    // Next-state logic.
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:
                if (arranque_ok)
                    estado_sig = primera_fase(IDLE, len_moler, len_agua, len_leche, len_espuma, len_azucar);
            MOLER, AGUA, LECHE, ESPUMA, AZUCAR:
                if (cnt_cero)
                    estado_sig = primera_fase(estado, len_moler, len_agua, len_leche, len_espuma, len_azucar);
            default:
                estado_sig = IDLE;
        endcase
`ifdef SECUENCIA_CANCELAR_EN
        if (cancelar && estado != IDLE) estado_sig = IDLE;
`endif
    end

    // Output logic, decoded from the next state so the registered outputs line up with fase.
    always_comb begin
        molino_d  = (estado_sig == MOLER);
        agua_d    = (estado_sig == AGUA);
        leche_d   = (estado_sig == LECHE);
        espuma_d  = (estado_sig == ESPUMA);
        azucar_d  = (estado_sig == AZUCAR);
        ocupado_d = (estado_sig != IDLE);
        listo_d   = (estado_sig == DONE);
        error_d   = (estado == IDLE) && start && (tamano == TAM_INVALIDO);
`ifdef SECUENCIA_CANCELAR_EN
        if (cancelar && estado != IDLE) error_d = 1'b1;
`endif
        case (estado_sig)
            MOLER:   duracion = len_moler;
            AGUA:    duracion = len_agua;
            LECHE:   duracion = len_leche;
            ESPUMA:  duracion = len_espuma;
            AZUCAR:  duracion = len_azucar;
            default: duracion = 8'd0;
        endcase
    end

    assign cnt_carga = (estado_sig != estado) && (duracion != 8'd0);

    temporizador_fase u_temporizador (
        .clk         (clk),
        .reset       (reset),
        .carga       (cnt_carga),
        .valor_carga (duracion - 8'd1),
        .valor       (cnt_valor),
        .cero        (cnt_cero)
    );

    // State, recipe and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= IDLE;
            receta        <= '0;
            molino        <= 1'b0;
            valvula_agua  <= 1'b0;
            valvula_leche <= 1'b0;
            espumador     <= 1'b0;
            dosif_azucar  <= 1'b0;
            ocupado       <= 1'b0;
            listo         <= 1'b0;
            error_sel     <= 1'b0;
        end else begin
            estado        <= estado_sig;
            if (arranque_ok) receta <= receta_ef;
            molino        <= molino_d;
            valvula_agua  <= agua_d;
            valvula_leche <= leche_d;
            espumador     <= espuma_d;
            dosif_azucar  <= azucar_d;
            ocupado       <= ocupado_d;
            listo         <= listo_d;
            error_sel     <= error_d;
        end
    end

    assign fase = estado;

endmodule

// File: tb/tb_secuenciador_dispensado.sv
// Scoreboard bench for secuenciador_dispensado; expected per-cycle outputs are queued
// from a recipe model when a start is driven and compared cycle by cycle.
module tb_secuenciador_dispensado;

    localparam int TM = 4, TA = 4, TL = 6, TE = 4, TZ = 2, ZMAX = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       concentracion = 1'b0, leche = 1'b0, espuma = 1'b0;
    logic [2:0] azucar_anadido = '0;
    logic [1:0] tamano = '0;
    logic       cancelar = 1'b0;
    logic       molino, valvula_agua, valvula_leche, espumador, dosif_azucar;
    logic       ocupado, listo, error_sel;
    logic [2:0] fase;

    int checks = 0;
    int errors = 0;
    logic [10:0] esperado_q[$];

    always #5 clk = ~clk;

    secuenciador_dispensado dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .concentracion  (concentracion),
        .leche          (leche),
        .espuma         (espuma),
        .azucar_anadido (azucar_anadido),
        .tamano         (tamano),
`ifdef SECUENCIA_CANCELAR_EN
        .cancelar       (cancelar),
`endif
        .molino         (molino),
        .valvula_agua   (valvula_agua),
        .valvula_leche  (valvula_leche),
        .espumador      (espumador),
        .dosif_azucar   (dosif_azucar),
        .ocupado        (ocupado),
        .listo          (listo),
        .error_sel      (error_sel),
        .fase           (fase)
    );

    // {fase, molino, agua, leche, espuma, azucar, ocupado, listo, error_sel}
    function automatic logic [10:0] observado();
        return {fase, molino, valvula_agua, valvula_leche, espumador, dosif_azucar,
                ocupado, listo, error_sel};
    endfunction

    task automatic empujar_fase(input logic [2:0] f, input logic [4:0] act, input int n);
        for (int i = 0; i < n; i++) esperado_q.push_back({f, act, 1'b1, 1'b0, 1'b0});
    endtask

    // Model of one accepted drink: phases, DONE, then one idle cycle. Returns phase-cycle sum.
    task automatic empujar_receta(input bit conc, input bit lec, input bit esp, input int az,
                                  input int tam, output int suma);
        int n_mol, n_agu, n_lec, n_esp, n_azu;
        n_mol = conc ? 2 * TM : TM;
        n_agu = TA * (tam + 1);
        n_lec = lec ? TL : 0;
        n_esp = esp ? TE : 0;
        n_azu = TZ * ((az > ZMAX) ? ZMAX : az);
        empujar_fase(3'b001, 5'b10000, n_mol);
        empujar_fase(3'b010, 5'b01000, n_agu);
        empujar_fase(3'b011, 5'b00100, n_lec);
        empujar_fase(3'b100, 5'b00010, n_esp);
        empujar_fase(3'b101, 5'b00001, n_azu);
        esperado_q.push_back({3'b110, 5'b00000, 1'b1, 1'b1, 1'b0});
        esperado_q.push_back(11'b0);
        suma = n_mol + n_agu + n_lec + n_esp + n_azu;
    endtask

    task automatic aplicar(input bit conc, input bit lec, input bit esp, input int az, input int tam);
        concentracion  = conc;
        leche          = lec;
        espuma         = esp;
        azucar_anadido = 3'(az);
        tamano         = 2'(tam);
    endtask

    // Drives start (held for 'hold' cycles) and drains the scoreboard.
    task automatic ejecutar(input string nombre, input int hold, input int lat_esperada);
        int ciclo, listo_ciclo;
        logic [10:0] esp_v, obs;
        @(negedge clk);
        start = 1'b1;
        ciclo = 0;
        listo_ciclo = -1;
        while (esperado_q.size() > 0) begin
            @(negedge clk);
            ciclo++;
            if (ciclo >= hold) start = 1'b0;
            esp_v = esperado_q.pop_front();
            obs = observado();
            checks++;
            if (obs !== esp_v) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", nombre, ciclo, obs, esp_v);
            end
            if (obs[1] === 1'b1 && listo_ciclo < 0) listo_ciclo = ciclo;
        end
        if (lat_esperada > 0) begin
            checks++;
            if (listo_ciclo != lat_esperada) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", nombre, listo_ciclo, lat_esperada);
            end
        end
    endtask

    task automatic esperar_fase(input string nombre, input logic [2:0] f);
        int n = 0;
        while (fase !== f && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fase !== f) begin
            errors++;
            $display("FAIL %s wait fase: got %b expected %b", nombre, fase, f);
        end
    endtask

    task automatic sin_listo(input string nombre, input int ciclos);
        int vistos = 0;
        for (int i = 0; i < ciclos; i++) begin
            @(negedge clk);
            if (listo === 1'b1) vistos++;
        end
        checks++;
        if (vistos != 0) begin
            errors++;
            $display("FAIL %s spurious listo: got %0d pulses expected 0", nombre, vistos);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (observado() !== 11'b0) begin
            errors++;
            $display("FAIL reset state: got %b expected %b", observado(), 11'b0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (observado() !== 11'b0) begin
            errors++;
            $display("FAIL idle after reset: got %b expected %b", observado(), 11'b0);
        end
    endtask

    task automatic test_negro();
        int s;
        aplicar(0, 0, 0, 0, 0);
        empujar_receta(0, 0, 0, 0, 0, s);
        ejecutar("negro", 1, 1 + s);
    endtask

    task automatic test_capuchino();
        int s;
        aplicar(1, 1, 1, 5, 2);
        empujar_receta(1, 1, 1, 5, 2, s);
        ejecutar("capuchino", 1, 41);
    endtask

    task automatic test_azucar_saturado();
        int s;
        aplicar(0, 0, 0, 7, 1);
        empujar_receta(0, 0, 0, 7, 1, s);
        ejecutar("azucar_sat", 1, 1 + s);
    endtask

    task automatic test_salto_leche();
        int s;
        aplicar(0, 0, 1, 1, 2);
        empujar_receta(0, 0, 1, 1, 2, s);
        ejecutar("salto_leche", 1, 1 + s);
    endtask

    task automatic test_tamano_invalido();
        aplicar(0, 1, 1, 3, 3);
        esperado_q.push_back({3'b000, 5'b00000, 1'b0, 1'b0, 1'b1});
        esperado_q.push_back(11'b0);
        esperado_q.push_back(11'b0);
        ejecutar("tamano_invalido", 1, 0);
    endtask

    task automatic test_reset_en_agua();
        int s;
        aplicar(1, 1, 1, 5, 2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        esperar_fase("reset_agua", 3'b010);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (observado() !== 11'b0) begin
            errors++;
            $display("FAIL reset_agua outputs: got %b expected %b", observado(), 11'b0);
        end
        reset = 1'b0;
        sin_listo("reset_agua", 45);
        aplicar(0, 0, 0, 0, 0);
        empujar_receta(0, 0, 0, 0, 0, s);
        ejecutar("tras_reset", 1, 1 + s);
    endtask

    task automatic test_back_to_back();
        int s1, s2;
        aplicar(0, 1, 0, 2, 0);
        empujar_receta(0, 1, 0, 2, 0, s1);
        void'(esperado_q.pop_back());
        esperado_q.push_back(11'b0);
        empujar_receta(0, 1, 0, 2, 0, s2);
        ejecutar("back_to_back", s1 + 3, 0);
    endtask

`ifdef SECUENCIA_CANCELAR_EN
    task automatic test_cancelar();
        aplicar(1, 1, 1, 5, 2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        esperar_fase("cancelar", 3'b011);
        cancelar = 1'b1;
        @(negedge clk);
        cancelar = 1'b0;
        checks++;
        if (observado() !== {3'b000, 5'b00000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL cancelar edge: got %b expected %b", observado(),
                     {3'b000, 5'b00000, 1'b0, 1'b0, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (observado() !== 11'b0) begin
            errors++;
            $display("FAIL cancelar idle: got %b expected %b", observado(), 11'b0);
        end
        sin_listo("cancelar", 40);
    endtask
`endif

    initial begin
        test_reset();
        test_negro();
        test_capuchino();
        test_azucar_saturado();
        test_salto_leche();
        test_tamano_invalido();
        test_reset_en_agua();
        test_back_to_back();
`ifdef SECUENCIA_CANCELAR_EN
        test_cancelar();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
